// File: rtl/pwm_drv_if.sv
// Control-side write port of pwm_drv: a signed duty word and its one-cycle strobe.
// Handshake: wrt_duty is a valid with no ready; the driver accepts every strobe and samples duty only while wrt_duty is high.
interface pwm_drv_if #(
    parameter int DW = 14
);
    logic [DW-1:0] duty;
    logic          wrt_duty;

    modport master (output duty, output wrt_duty);
    modport slave  (input  duty, input  wrt_duty);
endinterface

// File: rtl/pwm_drv.sv
// Dual-channel PWM driver: double-buffered signed duty, direction-reversal dead time,
// and a loss-of-update watchdog that disables both channels when writes stop.
module pwm_drv #(
    parameter int CNT_W       = 13,
    parameter int DEAD        = 64,
    parameter int TMO_PERIODS = 16
) (
    input  logic     clk,
    input  logic     rst,
    pwm_drv_if.slave ctl,
    output logic     CH_A,
    output logic     CH_B,
    output logic     pwm_active,
    output logic     prd_strt
);
    localparam int DW     = CNT_W + 1;
    localparam int WD_W   = $clog2(TMO_PERIODS + 1);
    localparam int DEAD_W = $clog2(DEAD + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [WD_W-1:0]   WD_TMO  = WD_W'(TMO_PERIODS);
    localparam logic [DEAD_W-1:0] DEAD_LD = DEAD_W'(DEAD);

    logic [CNT_W-1:0]  cnt;
    logic [DW-1:0]     shadow;
    logic [DW-1:0]     active;
    logic              dir;
    logic              armed;
    logic [DEAD_W-1:0] dead_cnt;
    logic [WD_W-1:0]   wd_cnt;

    logic              boundary;
    logic              trip;
    logic              dir_next;
    logic [DW-1:0]     new_duty;
    logic [DW-1:0]     load_duty;
    logic [WD_W-1:0]   wd_next;
    logic [CNT_W-1:0]  load_mag;
    logic [CNT_W-1:0]  mag;

    // The most negative word has no positive counterpart; it clamps to full scale.
    function automatic logic [CNT_W-1:0] mag_of(input logic [DW-1:0] d);
        if (!d[DW-1])
            return d[CNT_W-1:0];
        else if (d[CNT_W-1:0] == '0)
            return CNT_MAX;
        else
            return ~d[CNT_W-1:0] + CNT_W'(1);
    endfunction

    always_comb begin
        boundary = (cnt == CNT_MAX);
        new_duty = ctl.wrt_duty ? ctl.duty : shadow;
        if (ctl.wrt_duty)
            wd_next = '0;
        else if (boundary && (wd_cnt != WD_TMO))
            wd_next = wd_cnt + WD_W'(1);
        else
            wd_next = wd_cnt;
        trip      = boundary && (wd_next == WD_TMO);
        load_duty = trip ? '0 : new_duty;
        load_mag  = mag_of(load_duty);
        // A zero magnitude keeps the old direction so a same-sign restart needs no dead time.
        dir_next  = (load_mag != '0) ? ~load_duty[DW-1] : dir;
        mag       = mag_of(active);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            shadow     <= '0;
            active     <= '0;
            dir        <= 1'b1;
            armed      <= 1'b0;
            dead_cnt   <= '0;
            wd_cnt     <= '0;
            CH_A       <= 1'b0;
            CH_B       <= 1'b0;
            pwm_active <= 1'b0;
            prd_strt   <= 1'b0;
        end else begin
            cnt      <= cnt + CNT_W'(1);
            prd_strt <= boundary;
            wd_cnt   <= wd_next;
            if (ctl.wrt_duty) begin
                shadow <= ctl.duty;
                armed  <= 1'b1;
            end
            if (boundary) begin
                active     <= load_duty;
                dir        <= dir_next;
                pwm_active <= (armed | ctl.wrt_duty) & ~trip;
                dead_cnt   <= (dir_next != dir) ? DEAD_LD : '0;
            end else if (dead_cnt != '0) begin
                dead_cnt <= dead_cnt - DEAD_W'(1);
            end
            // Dead time masks the start of the pulse; the pulse end stays at cnt == mag.
            CH_A <= pwm_active &  dir & (cnt < mag) & (dead_cnt == '0);
            CH_B <= pwm_active & ~dir & (cnt < mag) & (dead_cnt == '0);
        end
    end
endmodule

// File: tb/tb_pwm_drv.sv
// Self-checking bench for pwm_drv: per-period pulse checks against a period-level reference model.
module tb_pwm_drv;
    localparam int CW   = 10;
    localparam int P    = 1 << CW;
    localparam int DW   = CW + 1;
    localparam int DEAD = 64;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst;
    logic CH_A, CH_B, pwm_active, prd_strt;

    pwm_drv_if #(.DW(DW)) ifc ();

    pwm_drv #(.CNT_W(CW), .DEAD(DEAD), .TMO_PERIODS(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctl        (ifc),
        .CH_A       (CH_A),
        .CH_B       (CH_B),
        .pwm_active (pwm_active),
        .prd_strt   (prd_strt)
    );

    always #5 clk = ~clk;

    int   n_assert;
    int   n_fail;
    int   m_shadow;
    int   m_wd;
    logic m_armed;
    logic m_dir;
    logic first;
    logic e_active;
    int   e_hi_a;
    int   e_hi_b;
    int   e_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= P) ? v - 2 * P : v;
    endfunction

    function automatic int mag_model(input int v);
        int s;
        int m;
        s = to_signed(v);
        m = (s < 0) ? -s : s;
        return (m > P - 1) ? P - 1 : m;
    endfunction

    task automatic model_reset();
        m_shadow = 0;
        m_wd     = 0;
        m_armed  = 1'b0;
        m_dir    = 1'b1;
        first    = 1'b1;
        e_active = 1'b0;
        e_hi_a   = 0;
        e_hi_b   = 0;
        e_start  = 1;
    endtask

    // Period-level view: what the next period looks like given the writes seen in this one.
    task automatic model_boundary(input int n_wr, input int last_pos, input int last_val);
        int   mag;
        int   hi;
        logic nd;
        logic dead;
        logic trip;
        if (n_wr > 0) begin
            m_shadow = last_val;
            m_armed  = 1'b1;
            m_wd     = (last_pos == P - 1) ? 0 : 1;
        end else begin
            m_wd = (m_wd < TMO) ? m_wd + 1 : TMO;
        end
        trip     = (m_wd == TMO);
        e_active = m_armed && !trip;
        mag      = trip ? 0 : mag_model(m_shadow);
        dead     = 1'b0;
        if (mag != 0) begin
            nd    = (to_signed(m_shadow) >= 0);
            dead  = (nd != m_dir);
            m_dir = nd;
        end
        if (!e_active)
            hi = 0;
        else if (dead)
            hi = (mag > DEAD) ? mag - DEAD : 0;
        else
            hi = mag;
        e_hi_a  = m_dir ? hi : 0;
        e_hi_b  = m_dir ? 0 : hi;
        e_start = dead ? DEAD + 1 : 1;
        first   = 1'b0;
    endtask

    // Runs one period starting in the cycle where cnt == 0; stop_at >= 0 resets mid-period.
    task automatic run_period(input int n_wr, input int pos0, input int val0,
                              input int pos1, input int val1, input int stop_at);
        int ca = 0, cb = 0, fa = -1, fb = -1, la = -1, lb = -1, ov = 0;
        for (int p = 0; p < P; p++) begin
            if (p == 0) begin
                chk("prd_strt", prd_strt, first ? 0 : 1);
                chk("wrap_slot_low", {CH_A, CH_B}, 0);
            end else begin
                if (p == 1) chk("pwm_active", pwm_active, e_active);
                if (CH_A) begin ca++; if (fa < 0) fa = p; la = p; end
                if (CH_B) begin cb++; if (fb < 0) fb = p; lb = p; end
                if (CH_A && CH_B) ov++;
            end
            if (p == stop_at) begin
                chk("mid_pulse_CH_A", CH_A, (e_hi_a > 0 && p >= e_start && p < e_start + e_hi_a) ? 1 : 0);
                rst = 1'b1;
                ifc.wrt_duty = 1'b0;
                @(posedge clk); #1;
                chk("rst_CH_A", CH_A, 0);
                chk("rst_CH_B", CH_B, 0);
                chk("rst_pwm_active", pwm_active, 0);
                chk("rst_prd_strt", prd_strt, 0);
                rst = 1'b0;
                model_reset();
                return;
            end
            ifc.wrt_duty = 1'b0;
            ifc.duty     = DW'($urandom);
            if (n_wr >= 2 && p == pos1) begin
                ifc.wrt_duty = 1'b1;
                ifc.duty     = DW'(val1);
            end else if (n_wr >= 1 && p == pos0) begin
                ifc.wrt_duty = 1'b1;
                ifc.duty     = DW'(val0);
            end
            @(posedge clk); #1;
        end
        ifc.wrt_duty = 1'b0;
        chk("high_cnt_A", ca, e_hi_a);
        chk("high_cnt_B", cb, e_hi_b);
        chk("overlap", ov, 0);
        if (e_hi_a > 0) begin
            chk("start_A", fa, e_start);
            chk("contig_A", la - fa + 1, ca);
        end
        if (e_hi_b > 0) begin
            chk("start_B", fb, e_start);
            chk("contig_B", lb - fb + 1, cb);
        end
        model_boundary(n_wr, (n_wr >= 2) ? pos1 : pos0, (n_wr >= 2) ? val1 : val0);
    endtask

    initial begin
        int n, a, b, v0, v1;
        n_assert     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        ifc.wrt_duty = 1'b0;
        ifc.duty     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_CH_A", CH_A, 0);
        chk("reset_CH_B", CH_B, 0);
        chk("reset_pwm_active", pwm_active, 0);
        chk("reset_prd_strt", prd_strt, 0);
        rst = 1'b0;
        model_reset();

        // Forward pulse, then reversal with dead time.
        run_period(1, 300, 'h100, 0, 0, -1);
        run_period(0, 0, 0, 0, 0, -1);
        run_period(1, 500, 'h700, 0, 0, -1);
        run_period(0, 0, 0, 0, 0, -1);
        run_period(0, 0, 0, 0, 0, -1);

        // Saturated negative, zero duty, then same-sign restart without dead time.
        run_period(1, 123, 'h400, 0, 0, -1);
        run_period(1, 800, 'h000, 0, 0, -1);
        run_period(1, 40, 'h700, 0, 0, -1);
        run_period(0, 0, 0, 0, 0, -1);

        // Two writes in one period, the last one in the boundary cycle.
        run_period(2, 100, 'h040, P - 1, 'h080, -1);
        run_period(0, 0, 0, 0, 0, -1);
        run_period(0, 0, 0, 0, 0, -1);

        // Watchdog trip and recovery.
        run_period(1, 10, 'h200, 0, 0, -1);
        repeat (18) run_period(0, 0, 0, 0, 0, -1);
        run_period(1, 700, 'h200, 0, 0, -1);
        run_period(0, 0, 0, 0, 0, -1);

        // Randomized writes.
        repeat (8) begin
            n  = $urandom_range(0, 2);
            a  = $urandom_range(0, P - 1);
            b  = $urandom_range(a, P - 1);
            if ($urandom_range(0, 3) == 0) b = P - 1;
            v0 = $urandom_range(0, 2 * P - 1);
            v1 = $urandom_range(0, 2 * P - 1);
            run_period(n, (n == 1) ? b : a, v0, b, v1, -1);
        end

        // Reset in the middle of a pulse, then silence until a fresh write.
        run_period(1, 50, 'h200, 0, 0, -1);
        run_period(0, 0, 0, 0, 0, 200);
        run_period(0, 0, 0, 0, 0, -1);
        run_period(0, 0, 0, 0, 0, -1);
        run_period(1, 600, 'h100, 0, 0, -1);
        run_period(0, 0, 0, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
